nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter TW_W, default 32: tuning-word width, matching the NCO phase-increment input.
REQ-002 SHALL have parameter DW_W, default 16: dwell-counter width.
REQ-003 SHALL have port clk_top  in  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_top  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  sweep request, sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  terminates sweep from any state.
REQ-007 SHALL have port mode  in  1  0 = single sweep, 1 = continuous (sawtooth repeat).
REQ-008 SHALL have port f_start  in  TW_W  first tuning word, unsigned.
REQ-009 SHALL have port f_stop  in  TW_W  last tuning word, unsigned.
REQ-010 SHALL have port f_step  in  TW_W  step magnitude, unsigned.
REQ-011 SHALL have port dwell  in  DW_W  cycles per frequency point; 0 treated as 1.
REQ-012 SHALL have port NCO_in  out  TW_W  tuning word to the downstream NCO.
REQ-013 SHALL have port NCO_enable  out  1  NCO run enable.
REQ-014 SHALL have port busy  out  1  high while sweeping.
REQ-015 SHALL have port done  out  1  one-cycle pulse at single-sweep completion.
REQ-016 SHALL have port wrap  out  1  one-cycle pulse when continuous sweep reloads f_start.

Function
REQ-017 SHALL implement FSM states IDLE, DWELL, STEP, FINISH.
REQ-018 SHALL, in IDLE with start=1 and abort=0, latch f_start, f_stop, f_step, dwell, mode, and direction (up if f_stop >= f_start, else down), then enter DWELL.
REQ-019 SHALL drive NCO_in=f_start, NCO_enable=1, busy=1 in the cycle after start is sampled.
REQ-020 SHALL hold each NCO_in value for exactly max(dwell,1) cycles.
REQ-021 SHALL, at dwell expiry, compute next = current ± f_step in TW_W+1 bits; if next passes or equals f_stop, or the sum overflows or underflows, clamp next to f_stop (no wrap-around of the tuning word).
REQ-022 SHALL advance NCO_in with no gap cycle between points; the STEP transition is combinationally overlapped with the last dwell cycle.
REQ-023 SHALL treat f_step=0 or f_start=f_stop as a single point: one dwell at f_start, then completion.
REQ-024 SHALL, after the f_stop dwell with latched mode=0, enter FINISH: done=1 and NCO_enable=0, busy=0 for that cycle, NCO_in holds f_stop; FINISH then returns to IDLE.
REQ-025 SHALL, after the f_stop dwell with latched mode=1, reload f_start on the next cycle and pulse wrap=1 in that cycle; NCO_enable stays 1.
REQ-026 SHALL ignore start while busy=1; input changes mid-sweep SHALL have no effect until the next start.
REQ-027 SHALL, on abort=1 in any state, enter IDLE next cycle with NCO_in=0, NCO_enable=0, busy=0, done=0, wrap=0; abort SHALL win over a simultaneous start.
REQ-028 SHALL keep NCO_in stable in IDLE, holding the last value, or 0 after reset or abort.

Reset
REQ-029 SHALL, on rst_top=1, immediately and asynchronously force state=IDLE, NCO_in=0, NCO_enable=0, busy=0, done=0, wrap=0, and dwell counter=0, including mid-sweep.
REQ-030 SHALL require a fresh start pulse after rst_top deasserts before any sweep resumes.

Verification
REQ-031 Bench SHALL cover an up sweep: f_start=1000, f_stop=1300, f_step=100, dwell=3, mode=0, start at cycle 0 -> NCO_in=1000 cycles 1-3, 1100 cycles 4-6, 1200 cycles 7-9, 1300 cycles 10-12; done=1 and NCO_enable=0 at cycle 13.
REQ-032 Bench SHALL cover a down sweep with clamp: f_start=50000, f_stop=49900, f_step=40, dwell=0 -> NCO_in 50000, 49960, 49920, 49900 on consecutive cycles, then done.
REQ-033 Bench SHALL cover overflow clamp: f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_step=0x100, dwell=1 -> 0xFFFFFF00 then 0xFFFFFFFF, with no wrap to a small value.
REQ-034 Bench SHALL cover continuous mode: f_start=0, f_stop=20, f_step=10, dwell=2, mode=1 -> NCO_in sequence 0,0,10,10,20,20,0,0,...; wrap=1 on each reload-to-0 cycle; done never asserts.
REQ-035 Bench SHALL cover abort and start in the same cycle mid-sweep -> next cycle IDLE, NCO_in=0, NCO_enable=0; start ignored.
REQ-036 Bench SHALL cover rst_top asserted between clock edges mid-dwell -> outputs reach reset values before the next clk_top edge; no activity until a new start.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for an NCO: steps a tuning word from f_start
// towards f_stop by f_step, holding each point for max(dwell,1) cycles,
// clamping the final point to f_stop. Single-shot or sawtooth-repeat.
module nco_sweep_ctrl #(
    parameter int TW_W = 32,
    parameter int DW_W = 16
) (
    input  logic            clk_top,
    input  logic            rst_top,
    input  logic            start,
    input  logic            abort,
    input  logic            mode,
    input  logic [TW_W-1:0] f_start,
    input  logic [TW_W-1:0] f_stop,
    input  logic [TW_W-1:0] f_step,
    input  logic [DW_W-1:0] dwell,
    output logic [TW_W-1:0] NCO_in,
    output logic            NCO_enable,
    output logic            busy,
    output logic            done,
    output logic            wrap
);

    // STEP is the last cycle of a dwell: the next point is computed while the
    // current one is still being output, so points follow with no gap.
    typedef enum logic [1:0] {IDLE, DWELL, STEP, FINISH} state_t;

    state_t          state, state_nxt;
    logic [TW_W-1:0] nco_q, nco_nxt;
    logic [DW_W-1:0] cnt_q, cnt_nxt;
    logic            wrap_q, wrap_nxt;

    // Sweep configuration captured at start; mid-sweep input changes are ignored.
    logic [TW_W-1:0] lat_start, lat_stop, lat_step;
    logic [DW_W-1:0] lat_reload;
    logic            lat_mode, lat_up;
    logic            load;

    // Cycles remaining after the first cycle of a point; dwell of 0 acts as 1.
    function automatic logic [DW_W-1:0] reload_of(input logic [DW_W-1:0] d);
        return (d == '0) ? '0 : d - DW_W'(1);
    endfunction

    // Next tuning word, clamped to the stop value on reaching/passing it or on
    // carry/borrow out of TW_W bits.
    function automatic logic [TW_W-1:0] next_point(
        input logic [TW_W-1:0] cur,
        input logic [TW_W-1:0] step,
        input logic [TW_W-1:0] stop,
        input logic            up
    );
        logic [TW_W:0] ext;
        if (up) begin
            ext = {1'b0, cur} + {1'b0, step};
            if (ext[TW_W] || (ext[TW_W-1:0] >= stop)) return stop;
        end else begin
            ext = {1'b0, cur} - {1'b0, step};
            if (ext[TW_W] || (ext[TW_W-1:0] <= stop)) return stop;
        end
        return ext[TW_W-1:0];
    endfunction

    assign load = (state == IDLE) && start && !abort;

    // Capture sweep parameters and direction when a sweep is accepted.
    always_ff @(posedge clk_top) begin
        if (load) begin
            lat_start  <= f_start;
            lat_stop   <= f_stop;
            lat_step   <= f_step;
            lat_reload <= reload_of(dwell);
            lat_mode   <= mode;
            lat_up     <= (f_stop >= f_start);
        end
    end

    // State, tuning word, dwell counter and wrap pulse registers.
    always_ff @(posedge clk_top or posedge rst_top) begin
        if (rst_top) begin
            state  <= IDLE;
            nco_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            nco_q  <= nco_nxt;
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    // Next-state, next tuning word and dwell counting.
    always_comb begin
        state_nxt = state;
        nco_nxt   = nco_q;
        cnt_nxt   = cnt_q;
        wrap_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            nco_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nco_nxt   = f_start;
                        cnt_nxt   = reload_of(dwell);
                        state_nxt = (reload_of(dwell) == '0) ? STEP : DWELL;
                    end
                end
                DWELL: begin
                    if (cnt_q <= DW_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = STEP;
                    end else begin
                        cnt_nxt = cnt_q - DW_W'(1);
                    end
                end
                STEP: begin
                    cnt_nxt   = lat_reload;
                    state_nxt = (lat_reload == '0) ? STEP : DWELL;
                    if ((nco_q == lat_stop) || (lat_step == '0)) begin
                        if (lat_mode) begin
                            nco_nxt  = lat_start;
                            wrap_nxt = 1'b1;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = FINISH;
                        end
                    end else begin
                        nco_nxt = next_point(nco_q, lat_step, lat_stop, lat_up);
                    end
                end
                FINISH: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign NCO_in     = nco_q;
    assign busy       = (state == DWELL) || (state == STEP);
    assign NCO_enable = busy;
    assign done       = (state == FINISH);
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: one table row per clock cycle, plus a
// hand-written asynchronous-reset sequence.
module tb_nco_sweep_ctrl;

    logic        clk_top = 1'b0;
    logic        rst_top;
    logic        start, abort, mode;
    logic [31:0] f_start, f_stop, f_step;
    logic [15:0] dwell;
    logic [31:0] NCO_in;
    logic        NCO_enable, busy, done, wrap;

    int checks = 0;
    int errors = 0;

    nco_sweep_ctrl #(.TW_W(32), .DW_W(16)) dut (
        .clk_top(clk_top), .rst_top(rst_top), .start(start), .abort(abort),
        .mode(mode), .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .dwell(dwell), .NCO_in(NCO_in), .NCO_enable(NCO_enable), .busy(busy),
        .done(done), .wrap(wrap)
    );

    always #5 clk_top = ~clk_top;

    typedef struct {
        logic        start, abort, mode;
        logic [31:0] fs, fe, st;
        logic [15:0] dw;
        logic [31:0] e_nco;
        logic        e_en, e_busy, e_done, e_wrap;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic a, input logic m,
                       input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                       input logic [15:0] dw, input logic [31:0] n,
                       input logic en, input logic bz, input logic dn, input logic wr);
        vec_t v;
        v.start = s; v.abort = a; v.mode = m;
        v.fs = fs; v.fe = fe; v.st = st; v.dw = dw;
        v.e_nco = n; v.e_en = en; v.e_busy = bz; v.e_done = dn; v.e_wrap = wr;
        vq.push_back(v);
    endtask

    // Start row: first point appears the cycle after start is sampled.
    task automatic sv(input logic m, input logic [31:0] fs, input logic [31:0] fe,
                      input logic [31:0] st, input logic [15:0] dw, input logic [31:0] n);
        add(1'b1, 1'b0, m, fs, fe, st, dw, n, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Sweeping row; inputs carry unrelated values that must be ignored.
    task automatic pt(input logic [31:0] n, input logic wr);
        add(1'b0, 1'b0, 1'b0, 32'd9999, 32'd7, 32'd5, 16'd4, n, 1'b1, 1'b1, 1'b0, wr);
    endtask

    task automatic fin(input logic [31:0] n);
        add(1'b0, 1'b0, 1'b0, 32'd9999, 32'd7, 32'd5, 16'd4, n, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idl(input logic [31:0] n);
        add(1'b0, 1'b0, 1'b0, 32'd9999, 32'd7, 32'd5, 16'd4, n, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got nco=%h en/busy/done/wrap=%b, want nco=%h en/busy/done/wrap=%b",
                     name, got[35:4], got[3:0], exp[35:4], exp[3:0]);
        end
    endtask

    function automatic logic [35:0] outs();
        return {NCO_in, NCO_enable, busy, done, wrap};
    endfunction

    task automatic tick();
        @(posedge clk_top);
        #1;
    endtask

    initial begin
        rst_top = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;

        // Up sweep, dwell 3; a mid-sweep start is ignored.
        sv(1'b0, 32'd1000, 32'd1300, 32'd100, 16'd3, 32'd1000);
        pt(32'd1000, 1'b0); pt(32'd1000, 1'b0);
        pt(32'd1100, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 16'd1, 32'd1100, 1'b1, 1'b1, 1'b0, 1'b0);
        pt(32'd1100, 1'b0);
        pt(32'd1200, 1'b0); pt(32'd1200, 1'b0); pt(32'd1200, 1'b0);
        pt(32'd1300, 1'b0); pt(32'd1300, 1'b0); pt(32'd1300, 1'b0);
        fin(32'd1300); idl(32'd1300);
        // Down sweep, dwell 0, final step clamped.
        sv(1'b0, 32'd50000, 32'd49900, 32'd40, 16'd0, 32'd50000);
        pt(32'd49960, 1'b0); pt(32'd49920, 1'b0); pt(32'd49900, 1'b0);
        fin(32'd49900); idl(32'd49900);
        // Carry out of 32 bits clamps to stop.
        sv(1'b0, 32'hFFFFFF00, 32'hFFFFFFFF, 32'h100, 16'd1, 32'hFFFFFF00);
        pt(32'hFFFFFFFF, 1'b0); fin(32'hFFFFFFFF); idl(32'hFFFFFFFF);
        // Single point: start equals stop.
        sv(1'b0, 32'd700, 32'd700, 32'd5, 16'd2, 32'd700);
        pt(32'd700, 1'b0); fin(32'd700); idl(32'd700);
        // Continuous sawtooth with wrap pulses, then abort with start.
        sv(1'b1, 32'd0, 32'd20, 32'd10, 16'd2, 32'd0);
        pt(32'd0, 1'b0); pt(32'd10, 1'b0); pt(32'd10, 1'b0);
        pt(32'd20, 1'b0); pt(32'd20, 1'b0); pt(32'd0, 1'b1);
        pt(32'd0, 1'b0); pt(32'd10, 1'b0); pt(32'd10, 1'b0);
        pt(32'd20, 1'b0); pt(32'd20, 1'b0); pt(32'd0, 1'b1);
        pt(32'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 32'd0, 32'd20, 32'd10, 16'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idl(32'd0);
        // Abort beats start in IDLE.
        add(1'b1, 1'b1, 1'b0, 32'd55, 32'd99, 32'd1, 16'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idl(32'd0);

        #12;
        check("reset_held", outs(), 36'h0);
        @(posedge clk_top); #1;
        rst_top = 1'b0;
        tick();
        check("idle_after_reset", outs(), 36'h0);

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start; abort = vq[i].abort; mode = vq[i].mode;
            f_start = vq[i].fs; f_stop = vq[i].fe; f_step = vq[i].st; dwell = vq[i].dw;
            tick();
            check($sformatf("row%0d", i), outs(),
                  {vq[i].e_nco, vq[i].e_en, vq[i].e_busy, vq[i].e_done, vq[i].e_wrap});
        end
        start = 1'b0; abort = 1'b0;

        // Asynchronous reset mid-dwell takes effect before the next edge.
        f_start = 32'd100; f_stop = 32'd500; f_step = 32'd100; dwell = 16'd5; mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_seq_start", outs(), {32'd100, 4'b1100});
        tick(); tick();
        check("rst_seq_mid", outs(), {32'd100, 4'b1100});
        #3 rst_top = 1'b1;
        #1 check("async_reset", outs(), 36'h0);
        #2 rst_top = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_reset_idle%0d", k), outs(), 36'h0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart", outs(), {32'd100, 4'b1100});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
